fft_r2sdf_stage: RTL and testbench
==================================

Name: fft_r2sdf_stage

Overview:
- Parametrised, streaming radix-2 decimation-in-frequency butterfly stage in single-path delay-feedback (SDF) form.
- Generalises the fixed parallel 8-point butterfly stages: one complex sample per valid cycle, delay depth 2^LOG2D, selectable data/twiddle widths, scaling and twiddle modes.
- Chained LOG2N instances (LOG2D = LOG2N-1 down to 0) form an N-point pipelined FFT. The parent supplies twiddles from its ROM.

Parameters:
- DW, 16, sample width per real/imag component, two's complement.
- TW, 16, twiddle width, Q1.(TW-1) signed.
- LOG2D, 2, log2 of delay depth D; frame length 2D.
- SCALE, 1, 1 = shift results right by 1 (floor); 0 = saturate to DW.
- TW_MODE, 0, 0 = no twiddle on difference path; 1 = multiply difference by tw_re/tw_im.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample qualifier.
- in_sof  in  1  first sample of frame; only meaningful with in_valid.
- in_re, in_im  in  DW each  input sample.
- tw_re, tw_im  in  TW each  twiddle for current phase-1 index k; sampled with in_valid; ignored when TW_MODE=0.
- out_valid  out  1  output qualifier.
- out_sof  out  1  first output (sum, k=0) of a frame.
- out_re, out_im  out  DW each  output sample.

Behaviour:
- Reset (rst=0, async): cnt=0, primed=0, out_valid=0, out_sof=0, out_re=out_im=0. Delay memory is not reset.
- cnt counts valid inputs mod 2D and holds when in_valid=0. Phase = cnt[LOG2D]; k = cnt[LOG2D-1:0].
- Delay memory has D entries, addressed by k. Each valid cycle it reads mem[k] (old content) and writes mem[k] in the same cycle.
- Phase 0 (cnt<D):
  - write mem[k] <= input.
  - output candidate = mem[k], the stored difference of the previous frame.
- Phase 1 (cnt>=D):
  - a = mem[k], b = input.
  - output candidate = S(a+b).
  - write mem[k] <= T(S(a-b)).
- S: compute sum/difference at DW+1 bits.
  - SCALE=1: arithmetic shift right 1.
  - SCALE=0: saturate to [-2^(DW-1), 2^(DW-1)-1].
- T: identity if TW_MODE=0. If TW_MODE=1, complex multiply:
  - re = dr*twr - di*twi; im = dr*twi + di*twr.
  - Add 2^(TW-2), arithmetic shift right TW-1, saturate to DW.
- Output register: one cycle after each valid input cycle, out_valid = 1 if (phase was 1) or primed; otherwise 0. out_re/out_im update only when out_valid=1 and hold otherwise.
- out_sof = 1 for the output produced from phase-1 index k=0.
- primed:
  - set when the last phase-1 sample (cnt=2D-1) is accepted.
  - cleared by reset or by a resync.
- Output order per frame: D sums (latency 1 from their b input), then D differences. The differences emerge during the next frame's phase 0 (latency D+1 valid cycles).
- in_sof handling, with in_valid=1:
  - Sample is treated as cnt=0.
  - If the internal cnt was already 0, primed is unchanged.
  - Otherwise (resync mid-frame), primed is cleared and the partial frame is discarded; no differences from it are emitted.
- in_sof without in_valid is ignored.
- Trailing D differences of the last frame are emitted only when D further valid inputs arrive. The parent pads with zeros to drain.
- in_valid gaps: no state change. Output values are unaffected by gap placement.

Test Plan:
- Priming, LOG2D=2, DW=16, SCALE=1, TW_MODE=0: feed re=0,2,4,6,8,10,12,14, im=0, in_sof on first, then 4 zeros -> out_valid low for first 4 inputs. Outputs then sums 4,6,8,10 (out_sof on 4), then diffs -4,-4,-4,-4, all im=0.
- Saturation, SCALE=0:
  - pairs (a,b) = (32767,1) -> sum 32767, diff 32766.
  - (-32768,1) -> sum -32767, diff -32768 (saturated).
  - (-32768,-32768) -> sum -32768.
- Twiddle, TW_MODE=1, SCALE=0: a=(100,50), b=(0,0), tw=(0,-32768) -> sum (100,50), diff (50,-100).
- in_valid gaps: repeat the priming scenario with in_valid low on every other cycle -> identical output sequence; out_valid never high on cycles not following a valid input.
- Resync: in_sof asserted at cnt=2 of the second frame -> primed cleared, no stale differences output. The next 4 inputs give out_valid=0, and correct sums follow.
- Async reset mid-frame: drop rst for a partial cycle during phase 1 -> outputs 0 and out_valid 0 immediately. After release, behaves as the fresh priming test.

Source files
------------

// File: rtl/fft_r2sdf_stage.sv
// Radix-2 DIF butterfly stage in single-path delay-feedback form: one complex sample per valid
// cycle, D = 2^LOG2D delay entries, optional twiddle multiply on the difference path.
module fft_r2sdf_stage #(
  parameter int unsigned DW      = 16,
  parameter int unsigned TW      = 16,
  parameter int unsigned LOG2D   = 2,
  parameter int unsigned SCALE   = 1,
  parameter int unsigned TW_MODE = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  input  logic          in_sof_i,
  input  logic [DW-1:0] in_re_i,
  input  logic [DW-1:0] in_im_i,
  input  logic [TW-1:0] tw_re_i,
  input  logic [TW-1:0] tw_im_i,
  output logic          out_valid_o,
  output logic          out_sof_o,
  output logic [DW-1:0] out_re_o,
  output logic [DW-1:0] out_im_o
);

  localparam int unsigned D  = 1 << LOG2D;
  localparam int unsigned CW = LOG2D + 1;
  localparam int unsigned KW = (LOG2D > 0) ? LOG2D : 1;
  localparam int unsigned PW = DW + TW;

  localparam logic [DW-1:0]        MaxV = {1'b0, {(DW - 1){1'b1}}};
  localparam logic [DW-1:0]        MinV = {1'b1, {(DW - 1){1'b0}}};
  localparam logic signed [PW:0]   MaxP = {{(PW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [PW:0]   MinP = {{(PW - DW + 2){1'b1}}, {(DW - 1){1'b0}}};
  localparam logic [PW:0]          Rnd  = (PW + 1)'(1) << (TW - 2);

  // Sum/difference at DW+1 bits back to DW: halve (floor) or clamp.
  function automatic logic [DW-1:0] scale_f(input logic [DW:0] x);
    logic [DW-1:0] r;
    if (SCALE != 0)              r = x[DW:1];
    else if (x[DW] != x[DW-1])   r = x[DW] ? MinV : MaxV;
    else                         r = x[DW-1:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] sat_f(input logic signed [PW:0] x);
    logic [DW-1:0] r;
    if (x > MaxP)      r = MaxV;
    else if (x < MinP) r = MinV;
    else               r = x[DW-1:0];
    return r;
  endfunction

  function automatic logic signed [PW-1:0] mul_f(input logic [DW-1:0] d, input logic [TW-1:0] t);
    logic signed [PW-1:0] de, te;
    de = {{TW{d[DW-1]}}, d};
    te = {{DW{t[TW-1]}}, t};
    return de * te;
  endfunction

  logic [CW-1:0]   cnt_q, cnt_d, cnt_eff;
  logic            primed_q, primed_d;
  logic            out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic [DW-1:0]   out_re_q, out_re_d, out_im_q, out_im_d;
  logic [DW-1:0]   mem_re_q [D];
  logic [DW-1:0]   mem_im_q [D];
  logic [KW-1:0]   k;
  logic            phase, resync;
  logic [DW-1:0]   a_re, a_im, sum_re, sum_im, dif_re, dif_im, t_re, t_im;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]   acc_re, acc_im;

  // A framed sample restarts the frame count at zero.
  assign cnt_eff = in_sof_i ? '0 : cnt_q;
  assign phase   = cnt_eff[LOG2D];
  assign resync  = in_valid_i & in_sof_i & (cnt_q != '0);

  if (LOG2D > 0) begin : g_k
    assign k = cnt_eff[KW-1:0];
  end else begin : g_k0
    assign k = '0;
  end

  always_comb begin
    a_re   = mem_re_q[k];
    a_im   = mem_im_q[k];
    sum_re = scale_f({a_re[DW-1], a_re} + {in_re_i[DW-1], in_re_i});
    sum_im = scale_f({a_im[DW-1], a_im} + {in_im_i[DW-1], in_im_i});
    dif_re = scale_f({a_re[DW-1], a_re} - {in_re_i[DW-1], in_re_i});
    dif_im = scale_f({a_im[DW-1], a_im} - {in_im_i[DW-1], in_im_i});
    p_rr   = mul_f(dif_re, tw_re_i);
    p_ii   = mul_f(dif_im, tw_im_i);
    p_ri   = mul_f(dif_re, tw_im_i);
    p_ir   = mul_f(dif_im, tw_re_i);
    acc_re = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii} + Rnd;
    acc_im = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir} + Rnd;
    if (TW_MODE != 0) begin
      t_re = sat_f(acc_re >>> (TW - 1));
      t_im = sat_f(acc_im >>> (TW - 1));
    end else begin
      t_re = dif_re;
      t_im = dif_im;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    if (in_valid_i) begin
      cnt_d = cnt_eff + CW'(1);
      if (resync)         primed_d = 1'b0;
      else if (&cnt_eff)  primed_d = 1'b1;
      // A resync drops the stale differences still sitting in memory.
      out_valid_d = phase | (primed_q & ~resync);
      out_sof_d   = phase & (k == '0);
      if (out_valid_d) begin
        out_re_d = phase ? sum_re : a_re;
        out_im_d = phase ? sum_im : a_im;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_valid_i) begin
      mem_re_q[k] <= phase ? t_re : in_re_i;
      mem_im_q[k] <= phase ? t_im : in_im_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_sof_o   = out_sof_q;
  assign out_re_o    = out_re_q;
  assign out_im_o    = out_im_q;

endmodule

// File: tb/tb_fft_r2sdf_stage.sv
// Directed bench for fft_r2sdf_stage: three parameterisations share one stimulus bus and
// each scenario checks the instance it targets against hand-computed vectors.
module tb_fft_r2sdf_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_sof = 1'b0;
  logic [15:0] in_re = '0, in_im = '0, tw_re = '0, tw_im = '0;
  logic        ov   [3];
  logic        osof [3];
  logic [15:0] ore  [3];
  logic [15:0] oim  [3];

  always #5 clk = ~clk;

  // 0: SCALE=1 plain, 1: SCALE=0 plain, 2: SCALE=0 with twiddle
  fft_r2sdf_stage #(.DW(16), .TW(16), .LOG2D(2), .SCALE(1), .TW_MODE(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_sof_i(in_sof),
    .in_re_i(in_re), .in_im_i(in_im), .tw_re_i(tw_re), .tw_im_i(tw_im),
    .out_valid_o(ov[0]), .out_sof_o(osof[0]), .out_re_o(ore[0]), .out_im_o(oim[0])
  );
  fft_r2sdf_stage #(.DW(16), .TW(16), .LOG2D(2), .SCALE(0), .TW_MODE(0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_sof_i(in_sof),
    .in_re_i(in_re), .in_im_i(in_im), .tw_re_i(tw_re), .tw_im_i(tw_im),
    .out_valid_o(ov[1]), .out_sof_o(osof[1]), .out_re_o(ore[1]), .out_im_o(oim[1])
  );
  fft_r2sdf_stage #(.DW(16), .TW(16), .LOG2D(2), .SCALE(0), .TW_MODE(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_sof_i(in_sof),
    .in_re_i(in_re), .in_im_i(in_im), .tw_re_i(tw_re), .tw_im_i(tw_im),
    .out_valid_o(ov[2]), .out_sof_o(osof[2]), .out_re_o(ore[2]), .out_im_o(oim[2])
  );

  typedef struct {
    logic v;
    logic sof;
    int   re, im, twr, twi;
    logic ev, esof;
    int   ere, eim;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int idx, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic sof, input int re, input int im,
                     input int twr, input int twi, input logic ev, input logic esof,
                     input int ere, input int eim);
    vec_t t;
    t.v = v; t.sof = sof; t.re = re; t.im = im; t.twr = twr; t.twi = twi;
    t.ev = ev; t.esof = esof; t.ere = ere; t.eim = eim;
    vecs.push_back(t);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_sof = 1'b0;
    in_re = '0; in_im = '0; tw_re = '0; tw_im = '0;
  endtask

  // Outputs are sampled 1 time unit after the edge that consumed each row.
  task automatic run_vecs(input string name, input int d);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid = vecs[i].v;
      in_sof   = vecs[i].sof;
      in_re    = 16'(vecs[i].re);
      in_im    = 16'(vecs[i].im);
      tw_re    = 16'(vecs[i].twr);
      tw_im    = 16'(vecs[i].twi);
      @(posedge clk);
      #1;
      check({name, ".valid"}, i, {31'b0, ov[d]}, {31'b0, vecs[i].ev});
      check({name, ".sof"}, i, {31'b0, osof[d]}, {31'b0, vecs[i].esof});
      if (vecs[i].ev) begin
        check({name, ".re"}, i, 32'($signed(ore[d])), vecs[i].ere);
        check({name, ".im"}, i, 32'($signed(oim[d])), vecs[i].eim);
      end
    end
    @(negedge clk);
    idle_inputs();
    vecs.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst.valid", d, {31'b0, ov[d]}, 32'sd0);
      check("rst.sof", d, {31'b0, osof[d]}, 32'sd0);
      check("rst.re", d, 32'($signed(ore[d])), 32'sd0);
      check("rst.im", d, 32'($signed(oim[d])), 32'sd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // re = 0,2,..,14 then zero padding: sums 2i-4 for the phase-1 inputs, differences all -4.
  task automatic add_priming(input int nrows, input logic sof0, input logic gaps);
    for (int i = 0; i < nrows; i++) begin
      int re;
      re = (i < 8) ? 2 * i : 0;
      add(1'b1, (i == 0) ? sof0 : 1'b0, re, 0, 0, 0, (i >= 4), (i == 4),
          (i < 8) ? 2 * i - 4 : -4, 0);
      if (gaps) add(1'b0, (i == 5), 999, -999, 0, 0, 1'b0, 1'b0, 0, 0);
    end
  endtask

  initial begin
    idle_inputs();

    do_reset();
    add_priming(12, 1'b1, 1'b0);
    run_vecs("prime", 0);

    do_reset();
    add_priming(12, 1'b1, 1'b1);
    run_vecs("gaps", 0);

    // Saturating sum/difference, including the most-negative corner cases.
    do_reset();
    add(1'b1, 1'b1,  32767, -5, 0, 0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0, -32768,  0, 0, 0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0, -32768,  0, 0, 0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0,      0,  0, 0, 0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0,      1,  3, 0, 0, 1'b1, 1'b1,  32767, -2);
    add(1'b1, 1'b0,      1,  0, 0, 0, 1'b1, 1'b0, -32767,  0);
    add(1'b1, 1'b0, -32768,  0, 0, 0, 1'b1, 1'b0, -32768,  0);
    add(1'b1, 1'b0,      0,  0, 0, 0, 1'b1, 1'b0,      0,  0);
    add(1'b1, 1'b0,      0,  0, 0, 0, 1'b1, 1'b0,  32766, -8);
    add(1'b1, 1'b0,      0,  0, 0, 0, 1'b1, 1'b0, -32768,  0);
    add(1'b1, 1'b0,      0,  0, 0, 0, 1'b1, 1'b0,      0,  0);
    add(1'b1, 1'b0,      0,  0, 0, 0, 1'b1, 1'b0,      0,  0);
    run_vecs("sat", 1);

    // Twiddle path: -j, ~1, overflow to +max, and +j with rounding.
    do_reset();
    add(1'b1, 1'b1,    100,     50,      0,      0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0,   1000,  -2000,      0,      0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0, -32768, -32768,      0,      0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0,      7,     -3,      0,      0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0,      0,      0,      0, -32768, 1'b1, 1'b1,    100,     50);
    add(1'b1, 1'b0,      0,      0,  32767,      0, 1'b1, 1'b0,   1000,  -2000);
    add(1'b1, 1'b0,      0,      0, -32768, -32768, 1'b1, 1'b0, -32768, -32768);
    add(1'b1, 1'b0,      1,      1,      0,  32767, 1'b1, 1'b0,      8,     -2);
    add(1'b1, 1'b0,      0,      0,      0,      0, 1'b1, 1'b0,     50,   -100);
    add(1'b1, 1'b0,      0,      0,      0,      0, 1'b1, 1'b0,   1000,  -2000);
    add(1'b1, 1'b0,      0,      0,      0,      0, 1'b1, 1'b0,      0,  32767);
    add(1'b1, 1'b0,      0,      0,      0,      0, 1'b1, 1'b0,      4,      6);
    run_vecs("twid", 2);

    // Resync at cnt=2 of the second frame: stale differences must not appear.
    do_reset();
    add_priming(8, 1'b1, 1'b0);
    add(1'b1, 1'b0, 100, 0, 0, 0, 1'b1, 1'b0, -4, 0);
    add(1'b1, 1'b0, 100, 0, 0, 0, 1'b1, 1'b0, -4, 0);
    add(1'b1, 1'b1,  20, 0, 0, 0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0,  22, 0, 0, 0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0,  24, 0, 0, 0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0,  26, 0, 0, 0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0,  30, 0, 0, 0, 1'b1, 1'b1, 25, 0);
    add(1'b1, 1'b0,  30, 0, 0, 0, 1'b1, 1'b0, 26, 0);
    add(1'b1, 1'b0,  30, 0, 0, 0, 1'b1, 1'b0, 27, 0);
    add(1'b1, 1'b0,  30, 0, 0, 0, 1'b1, 1'b0, 28, 0);
    add(1'b1, 1'b0,   0, 0, 0, 0, 1'b1, 1'b0, -5, 0);
    add(1'b1, 1'b0,   0, 0, 0, 0, 1'b1, 1'b0, -4, 0);
    add(1'b1, 1'b0,   0, 0, 0, 0, 1'b1, 1'b0, -3, 0);
    add(1'b1, 1'b0,   0, 0, 0, 0, 1'b1, 1'b0, -2, 0);
    run_vecs("resync", 0);

    // Asynchronous reset pulse in phase 1, away from any clock edge.
    do_reset();
    add_priming(6, 1'b1, 1'b0);
    run_vecs("pre_arst", 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 0, {31'b0, ov[0]}, 32'sd0);
    check("arst.sof", 0, {31'b0, osof[0]}, 32'sd0);
    check("arst.re", 0, 32'($signed(ore[0])), 32'sd0);
    check("arst.im", 0, 32'($signed(oim[0])), 32'sd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst.after", 0, {31'b0, ov[0]}, 32'sd0);
    // No in_sof here: the counter itself must have returned to zero.
    add_priming(12, 1'b0, 1'b0);
    run_vecs("post_arst", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
